calc_cmd_driver: RTL and testbench

Synthesizable initiator for the calculator's button/switch interface. It accepts (op, operand) commands over a valid/ready stream and replays each one onto the calc pins: operand on sw, op on btnl/btnc/btnr, one btnd update strobe or one btnu clear strobe. After a settle window it captures led and returns it on a valid/ready response stream. It sits between a command source (UART/ROM sequencer) and the calc instance, replacing hand-driven button stimulus.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_phase_timer.sv | 38 +++
 rtl/calc_cmd_driver.sv | 182 ++++++++++++++++++
 tb/tb_calc_cmd_driver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc command driver.
// Holds the op-code encodings driven onto {btnl,btnc,btnr}, the driver
// state encoding, and the default operand/led width.
package calc_pkg;

    localparam int unsigned CALC_DATA_W = 16;

    // Op-code encodings as seen on {btnl, btnc, btnr}
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LT  = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/calc_phase_timer.sv
// Loadable down-counter shared by the SETUP/PULSE/SETTLE phases.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       reload the counter with i_load_val
//   i_load_val   remaining cycles minus one for the phase being entered
//   o_done       high during the last cycle of the loaded phase
module calc_phase_timer #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // done is registered: it rises together with the counter reaching zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_load_val;
            r_done <= (i_load_val == '0);
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_done <= (r_cnt <= CNT_W'(1));
        end
    end

    assign o_done = r_done;

endmodule

// File: rtl/calc_cmd_driver.sv
// Replays (op, operand) commands onto the calc button/switch pins and
// returns the settled led value on a response stream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/ready/clear/op/operand  command stream (clear -> btnu)
//   calc_btnu/btnd                  clear / update strobes
//   calc_btnl/btnc/btnr, calc_sw    op select and operand pins
//   calc_led                        calc accumulator
//   rsp_valid/ready/data/seq        response stream
module calc_cmd_driver
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W        = CALC_DATA_W,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned PULSE_CYCLES  = 1,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SEQ_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_operand,
    output logic              calc_btnu,
    output logic              calc_btnd,
    output logic              calc_btnl,
    output logic              calc_btnc,
    output logic              calc_btnr,
    output logic [DATA_W-1:0] calc_sw,
    input  logic [DATA_W-1:0] calc_led,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [SEQ_W-1:0]  rsp_seq
);

    localparam int unsigned MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > SETTLE_CYCLES) ? MAX_SP : SETTLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES  == 0) ? 0 : SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_tmr_load;
    logic [CNT_W-1:0]   w_tmr_val;
    logic               w_tmr_done;
    logic               w_cmd_hs;
    logic               w_rsp_hs;

    logic               r_cmd_clear;
    logic [2:0]         r_cmd_op;
    logic [DATA_W-1:0]  r_cmd_operand;
    logic               r_cmd_ready;
    logic               r_btnu;
    logic               r_btnd;
    logic [2:0]         r_op_pins;
    logic [DATA_W-1:0]  r_sw;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [SEQ_W-1:0]   r_rsp_seq;

    assign w_cmd_hs = cmd_valid && r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid && rsp_ready;

    calc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and phase-timer reload on every phase entry
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_tmr_load = 1'b1;
                    if (SETUP_CYCLES == 0) begin
                        w_state_nxt = ST_PULSE;
                        w_tmr_val   = PULSE_LD;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_tmr_val   = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_PULSE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pin and response registers follow the phase one cycle behind the
    // state, which supplies the extra accept cycle in the latency budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_clear   <= 1'b0;
            r_cmd_op      <= '0;
            r_cmd_operand <= '0;
            r_cmd_ready   <= 1'b0;
            r_btnu        <= 1'b0;
            r_btnd        <= 1'b0;
            r_op_pins     <= '0;
            r_sw          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_seq     <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            if (w_cmd_hs) begin
                r_cmd_clear   <= cmd_clear;
                r_cmd_op      <= cmd_clear ? OP_ADD : cmd_op;
                r_cmd_operand <= cmd_clear ? '0 : cmd_operand;
            end
            if (r_state inside {ST_SETUP, ST_PULSE, ST_SETTLE}) begin
                r_sw      <= r_cmd_operand;
                r_op_pins <= r_cmd_op;
            end
            r_btnd <= (r_state == ST_PULSE) && !r_cmd_clear;
            r_btnu <= (r_state == ST_PULSE) && r_cmd_clear;
            // led is captured on the final edge of the settle window
            if ((r_state == ST_RESP) && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= calc_led;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_rsp_seq   <= r_rsp_seq + 1'b1;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign calc_btnu = r_btnu;
    assign calc_btnd = r_btnd;
    assign calc_btnl = r_op_pins[2];
    assign calc_btnc = r_op_pins[1];
    assign calc_btnr = r_op_pins[0];
    assign calc_sw   = r_sw;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_seq   = r_rsp_seq;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver: default instance driving a small calc
// model, plus a SETUP=0/PULSE=3/SETTLE=1 instance with a fixed led value.
module tb_calc_cmd_driver;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Default instance
    logic        cmd_valid, cmd_ready, cmd_clear;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic        calc_btnu, calc_btnd, calc_btnl, calc_btnc, calc_btnr;
    logic [15:0] calc_sw, calc_led;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_seq;

    // Parameter-sweep instance
    logic        cmd_valid2, cmd_ready2, cmd_clear2;
    logic [2:0]  cmd_op2;
    logic [15:0] cmd_operand2;
    logic        btnu2, btnd2, btnl2, btnc2, btnr2;
    logic [15:0] sw2, led2;
    logic        rsp_valid2, rsp_ready2;
    logic [15:0] rsp_data2;
    logic [7:0]  rsp_seq2;

    int n_pass  = 0;
    int n_total = 0;

    calc_cmd_driver u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .calc_btnu(calc_btnu), .calc_btnd(calc_btnd),
        .calc_btnl(calc_btnl), .calc_btnc(calc_btnc), .calc_btnr(calc_btnr),
        .calc_sw(calc_sw), .calc_led(calc_led),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_seq(rsp_seq)
    );

    calc_cmd_driver #(.SETUP_CYCLES(0), .PULSE_CYCLES(3), .SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_clear(cmd_clear2),
        .cmd_op(cmd_op2), .cmd_operand(cmd_operand2),
        .calc_btnu(btnu2), .calc_btnd(btnd2),
        .calc_btnl(btnl2), .calc_btnc(btnc2), .calc_btnr(btnr2),
        .calc_sw(sw2), .calc_led(led2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_seq(rsp_seq2)
    );

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_LT:   return {15'd0, (a < b)};
            OP_SLL:  return a << b[3:0];
            default: return 16'($signed(a) >>> b[3:0]);
        endcase
    endfunction

    // Calc model: acts on the rising edge of each strobe
    logic btnd_q, btnu_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_led <= '0;
            btnd_q   <= 1'b0;
            btnu_q   <= 1'b0;
        end else begin
            btnd_q <= calc_btnd;
            btnu_q <= calc_btnu;
            if (calc_btnu && !btnu_q)
                calc_led <= '0;
            else if (calc_btnd && !btnd_q)
                calc_led <= alu({calc_btnl, calc_btnc, calc_btnr}, calc_led, calc_sw);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Offer a command, wait for its response, check latency/strobes/pins
    task automatic send_cmd(input logic clr, input logic [2:0] op, input logic [15:0] opd,
                            input string tag);
        int n;
        int nd;
        int nu;
        cmd_valid   = 1'b1;
        cmd_clear   = clr;
        cmd_op      = op;
        cmd_operand = opd;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
        n  = 0;
        nd = 0;
        nu = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
            nd += int'(calc_btnd);
            nu += int'(calc_btnu);
        end
        chk({tag, "_latency"}, 32'(n), 32'd5);
        chk({tag, "_btnd_cycles"}, 32'(nd), clr ? 32'd0 : 32'd1);
        chk({tag, "_btnu_cycles"}, 32'(nu), clr ? 32'd1 : 32'd0);
        chk({tag, "_sw"}, 32'(calc_sw), clr ? 32'd0 : 32'(opd));
        chk({tag, "_op"}, 32'({calc_btnl, calc_btnc, calc_btnr}), clr ? 32'd0 : 32'(op));
    endtask

    task automatic check_rsp(input logic [15:0] d, input logic [7:0] s, input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(d));
        chk({tag, "_rsp_seq"}, 32'(rsp_seq), 32'(s));
    endtask

    // With rsp_ready high the handshake happens on the next edge
    task automatic ack(input string tag);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nd;
        int sw_at;
        int bd_at;

        rst_n = 1'b0;
        cmd_valid = 0; cmd_clear = 0; cmd_op = '0; cmd_operand = '0; rsp_ready = 1'b1;
        cmd_valid2 = 0; cmd_clear2 = 0; cmd_op2 = '0; cmd_operand2 = '0; rsp_ready2 = 1'b1;
        led2 = 16'h5a5a;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_strobes", 32'({calc_btnu, calc_btnd}), 32'd0);
        chk("rst_sw", 32'(calc_sw), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_seq}), 32'd0);
        rst_n = 1'b1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("rel_cmd_ready_edge", 32'(cmd_ready), 32'd1);

        // Parameter sweep: SETUP=0, PULSE=3, SETTLE=1
        cmd_valid2 = 1'b1; cmd_op2 = OP_ADD; cmd_operand2 = 16'h00aa;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        chk("sweep_ready_drop", 32'(cmd_ready2), 32'd0);
        n = 0; nd = 0; sw_at = 0; bd_at = 0;
        while (!rsp_valid2 && n < 50) begin
            @(negedge clk);
            n++;
            if (sw_at == 0 && sw2 == 16'h00aa) sw_at = n;
            if (bd_at == 0 && btnd2) bd_at = n;
            nd += int'(btnd2);
        end
        chk("sweep_sw_at", 32'(sw_at), 32'd1);
        chk("sweep_btnd_at", 32'(bd_at), 32'd1);
        chk("sweep_btnd_cycles", 32'(nd), 32'd3);
        chk("sweep_latency", 32'(n), 32'd5);
        chk("sweep_rsp_data", 32'(rsp_data2), 32'h5a5a);
        chk("sweep_rsp_seq", 32'(rsp_seq2), 32'd0);

        // Clear then OR/AND/ADD/SUB
        send_cmd(1'b1, OP_ADD, 16'hbeef, "clear");
        check_rsp(16'h0000, 8'd0, "clear");
        ack("clear");
        send_cmd(1'b0, OP_OR, 16'h1234, "or");
        check_rsp(16'h1234, 8'd1, "or");
        ack("or");
        send_cmd(1'b0, OP_AND, 16'h0ff0, "and");
        check_rsp(16'h0230, 8'd2, "and");
        ack("and");
        send_cmd(1'b0, OP_ADD, 16'h324f, "add");
        check_rsp(16'h347f, 8'd3, "add");
        ack("add");
        send_cmd(1'b0, OP_SUB, 16'h2d31, "sub");
        check_rsp(16'h074e, 8'd4, "sub");
        ack("sub");

        // Backpressure with a command waiting
        rsp_ready = 1'b0;
        send_cmd(1'b0, OP_XOR, 16'hffff, "xor");
        check_rsp(16'hf8b1, 8'd5, "xor");
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_op = OP_ADD; cmd_operand = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'hf8b1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_btnd", 32'(calc_btnd), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
        chk("bp_hs_seq", 32'(rsp_seq), 32'd6);
        send_cmd(1'b0, OP_ADD, 16'h0001, "queued");
        check_rsp(16'hf8b2, 8'd6, "queued");
        ack("queued");

        // Reset while btnd is high
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_op = OP_ADD; cmd_operand = 16'h0010;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!calc_btnd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midop_btnd_seen", 32'(calc_btnd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_btnd", 32'(calc_btnd), 32'd0);
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midop_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midop_seq", 32'(rsp_seq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midop_rel_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("midop_rel_ready_edge", 32'(cmd_ready), 32'd1);
        chk("midop_rel_seq", 32'(rsp_seq), 32'd0);
        chk("midop_rel_strobes", 32'({calc_btnu, calc_btnd, rsp_valid}), 32'd0);

        // 257 back-to-back increments, sequence number wraps
        send_cmd(1'b1, OP_ADD, 16'h0000, "wrap_clear");
        check_rsp(16'h0000, 8'd0, "wrap_clear");
        ack("wrap_clear");
        for (int i = 1; i <= 257; i++) begin
            send_cmd(1'b0, OP_ADD, 16'h0001, "inc");
            check_rsp(16'(i), 8'(i), "inc");
            ack("inc");
        end
        chk("final_data", 32'(rsp_data), 32'h0101);
        chk("final_seq", 32'(rsp_seq), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
